// File: rtl/bf16_cvt_arbiter.sv
// Round-robin front end sharing one BF16->FP32 converter between NREQ requesters.
// Tags track conversions in flight; results return in issue order through a credit-protected FIFO.
module bf16_cvt_arbiter #(
    parameter int NREQ       = 4,
    parameter int CVT_LAT    = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int IDW        = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*16-1:0]   req_data,
    output logic [15:0]          cvt_operand_a,
    input  logic [31:0]          cvt_result,
    input  logic                 cvt_invalid,
    input  logic                 cvt_overflow,
    input  logic                 cvt_underflow,
    input  logic                 cvt_inexact,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_result,
    output logic [3:0]           rsp_flags,
    output logic [3:0]           sticky_flags,
    input  logic                 sticky_clr,
    output logic                 busy
);

    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam int          CW     = $clog2(FIFO_DEPTH + CVT_LAT + 1);
    localparam int unsigned NREQ_U = NREQ;
    localparam int unsigned LAT_U  = CVT_LAT;

    logic [IDW-1:0]   r_rr_ptr;
    logic [CVT_LAT-1:0] r_tag_vld;
    logic [IDW-1:0]   r_tag_id [CVT_LAT];
    logic [IDW-1:0]   r_fifo_id  [FIFO_DEPTH];
    logic [31:0]      r_fifo_res [FIFO_DEPTH];
    logic [3:0]       r_fifo_flg [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [3:0]       r_sticky;

    logic [CW-1:0]    w_inflight;
    logic [CW-1:0]    w_occupancy;
    logic             w_credit;
    logic             w_found;
    logic             w_xfer;
    logic             w_push;
    logic             w_pop;
    logic [IDW-1:0]   w_idx;
    logic [IDW-1:0]   w_gnt_id;
    logic [IDW-1:0]   w_rr_next;
    logic [NREQ-1:0]  w_grant;
    logic [3:0]       w_cvt_flags;

    // Occupancy counts in-flight tags so every issued operand already owns a FIFO slot.
    always_comb begin
        w_inflight = '0;
        for (int unsigned k = 0; k < LAT_U; k++) begin
            w_inflight = w_inflight + CW'(r_tag_vld[k]);
        end
        w_occupancy = CW'(r_count) + w_inflight;
        w_credit    = w_occupancy < CW'(FIFO_DEPTH);
    end

    always_comb begin
        int unsigned idx;
        idx      = 0;
        w_idx    = '0;
        w_grant  = '0;
        w_gnt_id = '0;
        w_found  = 1'b0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            idx = 32'(r_rr_ptr) + k;
            if (idx >= NREQ_U) begin
                idx = idx - NREQ_U;
            end
            w_idx = IDW'(idx);
            if (!w_found && req_valid[w_idx]) begin
                w_found          = 1'b1;
                w_gnt_id         = w_idx;
                w_grant[w_idx]   = 1'b1;
            end
        end
        w_xfer    = w_credit && w_found;
        req_ready = w_credit ? w_grant : '0;
        w_rr_next = (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
    end

    always_comb begin
        cvt_operand_a = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            if (w_xfer && w_grant[i]) begin
                cvt_operand_a = req_data[16*i +: 16];
            end
        end
    end

    assign w_cvt_flags = {cvt_invalid, cvt_overflow, cvt_underflow, cvt_inexact};
    assign w_push      = r_tag_vld[CVT_LAT-1];
    assign w_pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr  <= '0;
            r_tag_vld <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_sticky  <= '0;
        end else begin
            if (w_xfer) begin
                r_rr_ptr <= w_rr_next;
            end
            r_tag_vld[0] <= w_xfer;
            for (int unsigned k = 1; k < LAT_U; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A clear coinciding with a push keeps the freshly pushed flags.
            if (sticky_clr) begin
                r_sticky <= w_push ? w_cvt_flags : '0;
            end else if (w_push) begin
                r_sticky <= r_sticky | w_cvt_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_tag_id[0] <= w_gnt_id;
        for (int unsigned k = 1; k < LAT_U; k++) begin
            r_tag_id[k] <= r_tag_id[k-1];
        end
        if (w_push) begin
            r_fifo_id[r_wr_ptr]  <= r_tag_id[CVT_LAT-1];
            r_fifo_res[r_wr_ptr] <= cvt_result;
            r_fifo_flg[r_wr_ptr] <= w_cvt_flags;
        end
    end

    assign rsp_valid    = (r_count != '0);
    assign rsp_id       = r_fifo_id[r_rd_ptr];
    assign rsp_result   = r_fifo_res[r_rd_ptr];
    assign rsp_flags    = r_fifo_flg[r_rd_ptr];
    assign sticky_flags = r_sticky;
    assign busy         = (|r_tag_vld) || rsp_valid;

endmodule

// File: tb/tb_bf16_cvt_arbiter.sv
// Directed bench for bf16_cvt_arbiter: vector table for single conversions plus
// hand-written sequences for round-robin, backpressure, reset flush and sticky clear.
module tb_bf16_cvt_arbiter;

    localparam int NREQ       = 4;
    localparam int CVT_LAT    = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int IDW        = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*16-1:0] req_data;
    logic [15:0]       cvt_operand_a;
    logic [31:0]       cvt_result;
    logic              cvt_invalid, cvt_overflow, cvt_underflow, cvt_inexact;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_result;
    logic [3:0]        rsp_flags;
    logic [3:0]        sticky_flags;
    logic              sticky_clr;
    logic              busy;

    always #5 clk = ~clk;

    bf16_cvt_arbiter #(
        .NREQ(NREQ),
        .CVT_LAT(CVT_LAT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .cvt_operand_a(cvt_operand_a), .cvt_result(cvt_result),
        .cvt_invalid(cvt_invalid), .cvt_overflow(cvt_overflow),
        .cvt_underflow(cvt_underflow), .cvt_inexact(cvt_inexact),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .sticky_flags(sticky_flags), .sticky_clr(sticky_clr), .busy(busy)
    );

    // Converter stub: one-cycle latency; 16'h7F80 injects an overflow flag.
    function automatic logic is_snan(input logic [15:0] op);
        return (op[14:7] == 8'hFF) && (op[6:0] != 7'd0) && !op[6];
    endfunction

    function automatic logic [31:0] cvt_res_f(input logic [15:0] op);
        if (is_snan(op)) return {op | 16'h0040, 16'h0000};
        return {op, 16'h0000};
    endfunction

    function automatic logic [3:0] cvt_flg_f(input logic [15:0] op);
        if (is_snan(op)) return 4'b1000;
        if (op == 16'h7F80) return 4'b0100;
        return 4'b0000;
    endfunction

    logic [31:0] stub_res;
    logic [3:0]  stub_flg;
    always_ff @(posedge clk) begin
        stub_res <= cvt_res_f(cvt_operand_a);
        stub_flg <= cvt_flg_f(cvt_operand_a);
    end
    assign cvt_result    = stub_res;
    assign cvt_invalid   = stub_flg[3];
    assign cvt_overflow  = stub_flg[2];
    assign cvt_underflow = stub_flg[1];
    assign cvt_inexact   = stub_flg[0];

    int errors = 0;
    int checks = 0;
    int n_rsp  = 0;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int          rid;
        logic [15:0] op;
        logic [31:0] res;
        logic [3:0]  flg;
        logic [3:0]  sticky;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard step for one cycle: check a popped head, record an accepted operand, advance.
    task automatic end_cycle();
        logic [NREQ-1:0] acc_v;
        exp_t e;
        #1;
        if (rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d result=%h, no response outstanding", rsp_id, rsp_result);
            end else begin
                e = sbq.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_result", rsp_result, e.res);
                chk("rsp_flags", 32'(rsp_flags), 32'(e.flg));
                n_rsp++;
            end
        end
        acc_v = req_valid & req_ready;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_v[i]) begin
                e.id  = i;
                e.res = cvt_res_f(req_data[16*i +: 16]);
                e.flg = cvt_flg_f(req_data[16*i +: 16]);
                sbq.push_back(e);
            end
        end
        tick();
    endtask

    task automatic drain(input string name);
        int b;
        b = 0;
        req_valid = '0;
        while (sbq.size() != 0 && b < 30) begin
            end_cycle();
            b++;
        end
        chk(name, 32'(sbq.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req_valid  = '0;
        sticky_clr = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        sbq.delete();
        n_rsp = 0;
    endtask

    initial begin
        int lat;
        int acc;
        int bound;
        logic hit;
        logic [15:0] d;

        reset      = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        rsp_ready  = 1'b0;
        sticky_clr = 1'b0;
        do_reset();
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_operand", 32'(cvt_operand_a), 32'd0);
        chk("reset_sticky", 32'(sticky_flags), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd0);

        // Single conversions, each issued from idle
        tbl[0] = '{0, 16'h3F80, 32'h3F80_0000, 4'b0000, 4'b0000};
        tbl[1] = '{2, 16'hC049, 32'hC049_0000, 4'b0000, 4'b0000};
        tbl[2] = '{3, 16'h7F81, 32'h7FC1_0000, 4'b1000, 4'b1000};
        tbl[3] = '{1, 16'h0000, 32'h0000_0000, 4'b0000, 4'b1000};
        tbl[4] = '{1, 16'h7FC0, 32'h7FC0_0000, 4'b0000, 4'b1000};
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_data = '0;
            req_data[16*tbl[i].rid +: 16] = tbl[i].op;
            req_valid = 4'(32'(1) << tbl[i].rid);
            #1;
            chk("tbl_ready", 32'(req_ready), 32'(1) << tbl[i].rid);
            chk("tbl_operand", 32'(cvt_operand_a), 32'(tbl[i].op));
            tick();
            req_valid = '0;
            lat = 1;
            while (!rsp_valid && lat < 10) begin
                tick();
                lat++;
            end
            chk("tbl_latency", 32'(lat), 32'(CVT_LAT + 1));
            chk("tbl_rsp_id", 32'(rsp_id), 32'(tbl[i].rid));
            chk("tbl_rsp_result", rsp_result, tbl[i].res);
            chk("tbl_rsp_flags", 32'(rsp_flags), 32'(tbl[i].flg));
            chk("tbl_sticky", 32'(sticky_flags), 32'(tbl[i].sticky));
            tick();
            chk("tbl_idle", 32'({rsp_valid, busy}), 32'd0);
        end
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        chk("sticky_cleared", 32'(sticky_flags), 32'd0);

        // Round robin with all requesters active
        do_reset();
        rsp_ready = 1'b1;
        req_data  = {16'h4040, 16'h4030, 16'h4020, 16'h4010};
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(1) << (c % 4));
            chk("rr_operand", 32'(cvt_operand_a), 32'h4010 + 32'(16 * (c % 4)));
            end_cycle();
        end
        drain("rr_drained");
        chk("rr_rsp_count", 32'(n_rsp), 32'd8);

        // Backpressure: credit limits accepts to FIFO_DEPTH, then everything drains
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        d   = 16'h4000;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            req_data = '0;
            req_data[31:16] = d;
            #1;
            hit = req_ready[1];
            end_cycle();
            if (hit) begin
                acc++;
                d++;
            end
        end
        chk("bp_accepts", 32'(acc), 32'(FIFO_DEPTH));
        #1;
        chk("bp_stall_ready", 32'(req_ready), 32'd0);
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        bound = 0;
        while (acc < 10 && bound < 40) begin
            req_data = '0;
            req_data[31:16] = d;
            #1;
            hit = req_ready[1];
            end_cycle();
            if (hit) begin
                acc++;
                d++;
            end
            bound++;
        end
        chk("bp_resumed", 32'(acc), 32'd10);
        drain("bp_drained");
        chk("bp_rsp_count", 32'(n_rsp), 32'(acc));
        chk("bp_idle", 32'({rsp_valid, busy}), 32'd0);

        // Reset with work queued and in flight
        do_reset();
        rsp_ready = 1'b0;
        req_data  = '0;
        req_data[15:0] = 16'h3F00;
        req_valid = 4'b0001;
        for (int c = 0; c < 4; c++) end_cycle();
        chk("flush_busy_before", 32'(busy), 32'd1);
        reset     = 1'b1;
        req_valid = '0;
        tick();
        reset = 1'b0;
        sbq.delete();
        chk("flush_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) end_cycle();
        chk("flush_no_rsp", 32'(rsp_valid), 32'd0);
        req_data  = {16'h4400, 16'h4300, 16'h4200, 16'h4100};
        req_valid = 4'hF;
        #1;
        chk("flush_next_grant", 32'(req_ready), 32'd1);
        chk("flush_next_operand", 32'(cvt_operand_a), 32'h4100);
        end_cycle();
        drain("flush_drained");

        // Sticky clear coincident with an overflow push
        rsp_ready = 1'b1;
        req_data  = '0;
        req_data[47:32] = 16'h7F81;
        req_valid = 4'b0100;
        end_cycle();
        req_valid = '0;
        repeat (3) end_cycle();
        chk("sticky_invalid", 32'(sticky_flags), 32'b1000);
        req_data[63:48] = 16'h7F80;
        req_valid = 4'b1000;
        end_cycle();
        req_valid  = '0;
        sticky_clr = 1'b1;
        end_cycle();
        sticky_clr = 1'b0;
        chk("clr_push_sticky", 32'(sticky_flags), 32'b0100);
        chk("ovf_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ovf_rsp_flags", 32'(rsp_flags), 32'b0100);
        drain("ovf_drained");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
